mskaes_share_encoder: RTL and testbench

- Input-side producer for MSKaes_32bits_core. Accepts an unmasked 128-bit plaintext and a 256-bit key over a valid/ready handshake.
- Draws fresh randomness as 32-bit words from a PRNG stream and builds a d-share Boolean masking.
- Presents the shares in shbus encoding on the core's valid_in/in_ready, sh_data_in and sh_key ports.
- Sits between the host/system interface and the masked core.

---
 rtl/mskaes_share_encoder_pkg.sv | 18 +
 rtl/mskaes_share_encoder_if.sv | 31 +++
 rtl/shares2shbus.sv | 17 +
 rtl/mskaes_share_encoder.sv | 116 +++++++++++
 tb/tb_mskaes_share_encoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mskaes_share_encoder_pkg.sv
// Shared constants and state encoding for the masked-AES input share encoder.
// Imported by the encoder interface and top module.
package mskaes_share_encoder_pkg;

    localparam int RND_W             = 32;
    localparam int DATA_W            = 128;
    localparam int KEY_W             = 256;
    localparam int N_WORDS_PER_SHARE = 12;
    localparam int DATA_WORDS        = 4;
    localparam int KEY_WORDS         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/mskaes_share_encoder_if.sv
// Host, randomness and core-side signals of the share encoder.
// master = encoder side, slave = environment (host, PRNG, core).
interface mskaes_share_encoder_if
    import mskaes_share_encoder_pkg::*;
#(
    parameter int d = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [KEY_W-1:0]      in_key;
    logic                  rnd_valid;
    logic                  rnd_ready;
    logic [RND_W-1:0]      rnd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W*d-1:0]   sh_data;
    logic [KEY_W*d-1:0]    sh_key;
    logic                  busy;

    modport master (
        input  in_valid, in_data, in_key, rnd_valid, rnd_data, out_ready,
        output in_ready, rnd_ready, out_valid, sh_data, sh_key, busy
    );

    modport slave (
        output in_valid, in_data, in_key, rnd_valid, rnd_data, out_ready,
        input  in_ready, rnd_ready, out_valid, sh_data, sh_key, busy
    );

endinterface

// File: rtl/shares2shbus.sv
// Rewires share-major registers into the bit-interleaved shbus layout:
// shbus[d*j+i] carries bit j of share i. Pure wiring, no logic.
module shares2shbus #(
    parameter int d     = 2,
    parameter int count = 128
) (
    input  logic [d-1:0][count-1:0] shares,
    output logic [count*d-1:0]      shbus
);

    for (genvar j = 0; j < count; j++) begin : g_bit
        for (genvar i = 0; i < d; i++) begin : g_share
            assign shbus[d*j+i] = shares[i][j];
        end
    end

endmodule

// File: rtl/mskaes_share_encoder.sv
// Builds a d-share Boolean masking of plaintext and key from PRNG words and
// presents it to the masked core in shbus encoding; one transaction in flight.
module mskaes_share_encoder
    import mskaes_share_encoder_pkg::*;
#(
    parameter int d = 2
) (
    input logic                    clk,
    input logic                    rst,
    mskaes_share_encoder_if.master bus
);

    localparam int N     = N_WORDS_PER_SHARE * (d - 1);
    localparam int LAST  = (N > 0) ? N - 1 : 0;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = (d > 1) ? $clog2(d) : 1;

    state_e                    state;
    state_e                    next_state;
    logic [CNT_W-1:0]          cnt;
    logic [d-1:0][DATA_W-1:0]  s_data;
    logic [d-1:0][KEY_W-1:0]   s_key;
    logic [SH_W-1:0]           share_idx;
    int                        slot;
    logic [6:0]                data_lsb;
    logic [7:0]                key_lsb;
    logic                      last_word;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state    = state;
        bus.in_ready  = 1'b0;
        bus.rnd_ready = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) next_state = (d > 1) ? FILL : OUT;
            end
            FILL: begin
                bus.rnd_ready = 1'b1;
                if (bus.rnd_valid && last_word) next_state = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Word k lands in share 1+k/12; slots 0..3 are data words, 4..11 key words.
    always_comb begin
        share_idx = SH_W'(1 + int'(cnt) / N_WORDS_PER_SHARE);
        slot      = int'(cnt) % N_WORDS_PER_SHARE;
        data_lsb  = 7'(slot * RND_W);
        key_lsb   = 8'((slot - DATA_WORDS) * RND_W);
        last_word = (cnt == CNT_W'(LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            s_data <= '0;
            s_key  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        s_data    <= '0;
                        s_key     <= '0;
                        s_data[0] <= bus.in_data;
                        s_key[0]  <= bus.in_key;
                        cnt       <= '0;
                    end
                end
                FILL: begin
                    if (d > 1 && bus.rnd_valid) begin
                        if (slot < DATA_WORDS) begin
                            s_data[share_idx][data_lsb +: RND_W] <= bus.rnd_data;
                            s_data[0][data_lsb +: RND_W] <= s_data[0][data_lsb +: RND_W] ^ bus.rnd_data;
                        end else begin
                            s_key[share_idx][key_lsb +: RND_W] <= bus.rnd_data;
                            s_key[0][key_lsb +: RND_W] <= s_key[0][key_lsb +: RND_W] ^ bus.rnd_data;
                        end
                        if (!last_word) cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    // Wipe every share once the core has taken them.
                    if (bus.out_ready) begin
                        s_data <= '0;
                        s_key  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    shares2shbus #(.d(d), .count(DATA_W)) u_data_shbus (
        .shares (s_data),
        .shbus  (bus.sh_data)
    );

    shares2shbus #(.d(d), .count(KEY_W)) u_key_shbus (
        .shares (s_key),
        .shbus  (bus.sh_key)
    );

endmodule

// File: tb/tb_mskaes_share_encoder.sv
// Directed bench for the share encoder: d=2 vector table plus hand-written
// d=3, d=1, hold-in-OUT and mid-FILL reset sequences.
module tb_mskaes_share_encoder;
    import mskaes_share_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    logic rnd1_seen    = 1'b0;

    always #5 clk = ~clk;

    mskaes_share_encoder_if #(.d(2)) bus2 ();
    mskaes_share_encoder_if #(.d(3)) bus3 ();
    mskaes_share_encoder_if #(.d(1)) bus1 ();

    mskaes_share_encoder #(.d(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mskaes_share_encoder #(.d(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    mskaes_share_encoder #(.d(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [127:0] data;
        logic [255:0] key;
        logic [31:0]  seed;
        logic [31:0]  step;
        bit           stall;
        int           hold;
        int           exp_cycles;
    } vec_t;

    vec_t vecs[3];

    always @(negedge clk) if (bus1.rnd_ready === 1'b1) rnd1_seen <= 1'b1;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] data_share2(input logic [255:0] sh, input int i);
        logic [127:0] r;
        for (int j = 0; j < 128; j++) r[j] = sh[2*j+i];
        return r;
    endfunction

    function automatic logic [255:0] key_share2(input logic [511:0] sh, input int i);
        logic [255:0] r;
        for (int j = 0; j < 256; j++) r[j] = sh[2*j+i];
        return r;
    endfunction

    function automatic logic [31:0] word_of(input vec_t v, input int k);
        return v.seed + v.step * 32'(k);
    endfunction

    // Runs one d=2 transaction up to OUT (or until abort_after words are sent).
    task automatic applyStimulus(input vec_t v, input int abort_after, output int cycles, output int words);
        cycles = 0;
        words  = 0;
        @(negedge clk);
        bus2.in_data   = v.data;
        bus2.in_key    = v.key;
        bus2.in_valid  = 1'b1;
        bus2.rnd_valid = 1'b0;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            bus2.in_valid = 1'b0;
            if (cycles == 1) checkOutput("in_ready_in_fill", 256'(bus2.in_ready), 256'd0);
            if (bus2.out_valid || words == abort_after) break;
            bus2.rnd_valid = v.stall ? (cycles % 2 == 0) : 1'b1;
            bus2.rnd_data  = word_of(v, words);
            if (bus2.rnd_valid && bus2.rnd_ready) words++;
        end
        bus2.rnd_valid = 1'b0;
    endtask

    task automatic verifyTransaction(input vec_t v, input int cycles, input int words);
        logic [127:0] exp_d1;
        logic [255:0] exp_k1;
        logic [127:0] snap_d;
        bit           stable;
        for (int r = 0; r < 4; r++) exp_d1[32*r +: 32] = word_of(v, r);
        for (int r = 0; r < 8; r++) exp_k1[32*r +: 32] = word_of(v, r + 4);
        checkOutput("latency", 256'(cycles), 256'(v.exp_cycles));
        checkOutput("words_used", 256'(words), 256'd12);
        checkOutput("out_valid", 256'(bus2.out_valid), 256'd1);
        checkOutput("busy_out", 256'(bus2.busy), 256'd1);
        checkOutput("rnd_ready_out", 256'(bus2.rnd_ready), 256'd0);
        checkOutput("recomb_data", 256'(data_share2(bus2.sh_data, 0) ^ data_share2(bus2.sh_data, 1)), 256'(v.data));
        checkOutput("recomb_key", key_share2(bus2.sh_key, 0) ^ key_share2(bus2.sh_key, 1), v.key);
        checkOutput("share1_data", 256'(data_share2(bus2.sh_data, 1)), 256'(exp_d1));
        checkOutput("share1_key", key_share2(bus2.sh_key, 1), exp_k1);
        checkOutput("share0_data", 256'(data_share2(bus2.sh_data, 0)), 256'(v.data ^ exp_d1));
        snap_d = data_share2(bus2.sh_data, 0);
        stable = 1'b1;
        for (int c = 0; c < v.hold; c++) begin
            @(negedge clk);
            if (bus2.out_valid !== 1'b1 || data_share2(bus2.sh_data, 0) !== snap_d ||
                key_share2(bus2.sh_key, 1) !== exp_k1) stable = 1'b0;
        end
        checkOutput("hold_stable", 256'(stable), 256'd1);
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        checkOutput("cleared_data", 256'(bus2.sh_data == '0), 256'd1);
        checkOutput("cleared_key", 256'(bus2.sh_key == '0), 256'd1);
        checkOutput("in_ready_after", 256'(bus2.in_ready), 256'd1);
        checkOutput("out_valid_after", 256'(bus2.out_valid), 256'd0);
    endtask

    initial begin
        int           cycles;
        int           words;
        bit           busy_ok;
        logic [31:0]  wds[24];
        logic [127:0] rec_d;
        logic [255:0] rec_k;
        logic [127:0] exp_s2;

        vecs[0] = '{128'h0, 256'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, 13};
        vecs[1] = '{128'hffeeddcc_bbaa9988_77665544_33221100,
                    256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100,
                    32'h9e37_79b9, 32'h7f4a_7c15, 1'b0, 50, 13};
        vecs[2] = '{128'h01234567_89abcdef_fedcba98_76543210,
                    256'hdeadbeef_cafef00d_0badc0de_12345678_a5a5a5a5_5a5a5a5a_00ff00ff_c3c3c3c3,
                    32'h1357_9bdf, 32'h2468_ace1, 1'b1, 0, 25};

        rst = 1'b1;
        {bus2.in_valid, bus2.rnd_valid, bus2.out_ready} = '0;
        {bus3.in_valid, bus3.rnd_valid, bus3.out_ready} = '0;
        {bus1.in_valid, bus1.out_ready} = '0;
        bus1.rnd_valid = 1'b1;
        bus2.in_data = '0; bus2.in_key = '0; bus2.rnd_data = '0;
        bus3.in_data = '0; bus3.in_key = '0; bus3.rnd_data = '0;
        bus1.in_data = '0; bus1.in_key = '0; bus1.rnd_data = 32'hdead_beef;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 256'(bus2.in_ready), 256'd1);
        checkOutput("rst_out_valid", 256'(bus2.out_valid), 256'd0);
        checkOutput("rst_rnd_ready", 256'(bus2.rnd_ready), 256'd0);
        checkOutput("rst_busy", 256'(bus2.busy), 256'd0);
        checkOutput("rst_sh_zero", 256'(bus2.sh_data == '0 && bus2.sh_key == '0), 256'd1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i], -1, cycles, words);
            verifyTransaction(vecs[i], cycles, words);
        end

        // Abandon a transaction after five words, then run a clean one.
        applyStimulus(vecs[1], 5, cycles, words);
        checkOutput("abort_busy", 256'(bus2.busy), 256'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_in_ready", 256'(bus2.in_ready), 256'd1);
        checkOutput("abort_out_valid", 256'(bus2.out_valid), 256'd0);
        checkOutput("abort_sh_zero", 256'(bus2.sh_data == '0 && bus2.sh_key == '0), 256'd1);
        applyStimulus(vecs[1], -1, cycles, words);
        verifyTransaction(vecs[1], cycles, words);

        // d=3 with rnd_valid toggling, first FILL cycle stalled.
        @(negedge clk);
        bus3.in_data  = vecs[1].data;
        bus3.in_key   = vecs[1].key;
        bus3.in_valid = 1'b1;
        cycles  = 0;
        words   = 0;
        busy_ok = 1'b1;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            bus3.in_valid = 1'b0;
            if (bus3.busy !== 1'b1) busy_ok = 1'b0;
            if (bus3.out_valid) break;
            bus3.rnd_valid = (cycles % 2 == 0);
            bus3.rnd_data  = $urandom;
            if (bus3.rnd_valid && bus3.rnd_ready) begin
                if (words < 24) wds[words] = bus3.rnd_data;
                words++;
            end
        end
        bus3.rnd_valid = 1'b0;
        for (int j = 0; j < 128; j++) rec_d[j] = bus3.sh_data[3*j] ^ bus3.sh_data[3*j+1] ^ bus3.sh_data[3*j+2];
        for (int j = 0; j < 256; j++) rec_k[j] = bus3.sh_key[3*j] ^ bus3.sh_key[3*j+1] ^ bus3.sh_key[3*j+2];
        for (int j = 0; j < 128; j++) exp_s2[j] = wds[12 + j/32][j%32];
        checkOutput("d3_latency", 256'(cycles), 256'd49);
        checkOutput("d3_words", 256'(words), 256'd24);
        checkOutput("d3_busy", 256'(busy_ok), 256'd1);
        checkOutput("d3_recomb_data", 256'(rec_d), 256'(vecs[1].data));
        checkOutput("d3_recomb_key", rec_k, vecs[1].key);
        for (int j = 0; j < 128; j++) rec_d[j] = bus3.sh_data[3*j+2];
        checkOutput("d3_share2_data", 256'(rec_d), 256'(exp_s2));
        bus3.out_ready = 1'b1;
        @(negedge clk);
        bus3.out_ready = 1'b0;
        checkOutput("d3_cleared", 256'(bus3.sh_data == '0 && bus3.sh_key == '0 && bus3.in_ready), 256'd1);

        // d=1 passes the secret straight to OUT without touching randomness.
        @(negedge clk);
        bus1.in_data  = 128'h5ac50f1e_2d3c4b5a_69788796_a5b4c469;
        bus1.in_key   = vecs[2].key;
        bus1.in_valid = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        checkOutput("d1_out_valid", 256'(bus1.out_valid), 256'd1);
        checkOutput("d1_sh_data", 256'(bus1.sh_data), 256'(128'h5ac50f1e_2d3c4b5a_69788796_a5b4c469));
        checkOutput("d1_sh_key", bus1.sh_key, vecs[2].key);
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        checkOutput("d1_cleared", 256'(bus1.sh_data == '0 && bus1.in_ready), 256'd1);
        checkOutput("d1_rnd_ready_seen", 256'(rnd1_seen), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
